// File: rtl/inst_fifo_pkg.sv
// Shared types and defaults for the fetch-to-decode instruction queue.
// Pure definitions: no latency or backpressure of its own.
package inst_fifo_pkg;

    localparam int INST_FIFO_DEPTH_DEFAULT = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fifo_entry_t;

    // Number of entries asked for by a primary/secondary enable pair;
    // the secondary is ignored unless the primary is also set.
    function automatic logic [1:0] req_count(input logic en1, input logic en2);
        return {1'b0, en1} + {1'b0, en1 & en2};
    endfunction

endpackage

// File: rtl/inst_fifo_perf.sv
// Saturating pop/empty event counters for the instruction queue; cleared only by rst.
// Counts are registered: an event at edge N shows at N+1; never stalls anything.
module inst_fifo_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_pop_dual,
    input  logic        i_pop_single,
    input  logic        i_empty,
    output logic [31:0] o_dual_cnt,
    output logic [31:0] o_single_cnt,
    output logic [31:0] o_empty_cnt
);

    logic [31:0] r_dual_cnt;
    logic [31:0] r_single_cnt;
    logic [31:0] r_empty_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dual_cnt   <= '0;
            r_single_cnt <= '0;
            r_empty_cnt  <= '0;
        end else begin
            if (i_pop_dual && (r_dual_cnt != '1))
                r_dual_cnt <= r_dual_cnt + 32'd1;
            if (i_pop_single && (r_single_cnt != '1))
                r_single_cnt <= r_single_cnt + 32'd1;
            if (i_empty && (r_empty_cnt != '1))
                r_empty_cnt <= r_empty_cnt + 32'd1;
        end
    end

    assign o_dual_cnt   = r_dual_cnt;
    assign o_single_cnt = r_single_cnt;
    assign o_empty_cnt  = r_empty_cnt;

endmodule

// File: rtl/inst_fifo.sv
// inst_fifo: dual-push/dual-pop fetch->decode instruction queue; INST_FIFO_PERF_EN adds perf counters.
// Pushes visible one cycle later; no backpressure wait: oversized pushes are dropped whole, over-pops clamp.
module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = INST_FIFO_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        write_en1,
    input  logic        write_en2,
    input  logic [31:0] write_addr1,
    input  logic [31:0] write_addr2,
    input  logic [31:0] write_data1,
    input  logic [31:0] write_data2,
    input  logic        read_en1,
    input  logic        read_en2,
    output logic [31:0] read_addr1,
    output logic [31:0] read_data1,
    output logic [31:0] read_addr2,
    output logic [31:0] read_data2,
    output logic        fifo_empty,
    output logic        fifo_almost_empty,
    output logic        fifo_full,
    output logic [31:0] perf_dual_cnt,
    output logic [31:0] perf_single_cnt,
    output logic [31:0] perf_empty_cnt
);

    fifo_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W:0]   r_count;

    logic [1:0]       w_npush_req;
    logic [1:0]       w_npop_req;
    logic [1:0]       w_npush;
    logic [1:0]       w_npop;
    logic [PTR_W:0]   w_free;
    logic             w_push_ok;
    logic [PTR_W-1:0] w_rptr_p1;
    logic [PTR_W-1:0] w_wptr_p1;

    assign w_npush_req = req_count(write_en1, write_en2);
    assign w_npop_req  = req_count(read_en1, read_en2);

    // Free space uses the pre-cycle count only; a same-cycle pop gives no credit.
    assign w_free    = (PTR_W+1)'(DEPTH) - r_count;
    assign w_push_ok = w_free >= (PTR_W+1)'(w_npush_req);
    assign w_npush   = w_push_ok ? w_npush_req : 2'd0;

    // Only counts of 0 or 1 can be short of a dual pop, so the low bits suffice.
    assign w_npop = (r_count >= (PTR_W+1)'(w_npop_req)) ? w_npop_req : r_count[1:0];

    assign w_rptr_p1 = r_rptr + 1'b1;
    assign w_wptr_p1 = r_wptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            r_rptr  <= r_rptr + PTR_W'(w_npop);
            r_wptr  <= r_wptr + PTR_W'(w_npush);
            r_count <= r_count + (PTR_W+1)'(w_npush) - (PTR_W+1)'(w_npop);
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && (w_npush != 2'd0)) begin
            r_mem[r_wptr] <= '{addr: write_addr1, data: write_data1};
            if (w_npush == 2'd2)
                r_mem[w_wptr_p1] <= '{addr: write_addr2, data: write_data2};
        end
    end

    assign read_addr1 = r_mem[r_rptr].addr;
    assign read_data1 = r_mem[r_rptr].data;
    assign read_addr2 = r_mem[w_rptr_p1].addr;
    assign read_data2 = r_mem[w_rptr_p1].data;

    assign fifo_empty        = (r_count == '0);
    assign fifo_almost_empty = (r_count == (PTR_W+1)'(1));
    assign fifo_full         = (r_count >= (PTR_W+1)'(DEPTH - 1));

`ifdef INST_FIFO_PERF_EN
    logic w_pop_dual;
    logic w_pop_single;

    // A flushed cycle discards its pops, so it counts as neither kind.
    assign w_pop_dual   = !flush && (w_npop == 2'd2);
    assign w_pop_single = !flush && (w_npop == 2'd1);

    inst_fifo_perf u_perf (
        .clk          (clk),
        .rst          (rst),
        .i_pop_dual   (w_pop_dual),
        .i_pop_single (w_pop_single),
        .i_empty      (fifo_empty),
        .o_dual_cnt   (perf_dual_cnt),
        .o_single_cnt (perf_single_cnt),
        .o_empty_cnt  (perf_empty_cnt)
    );
`else
    assign perf_dual_cnt   = 32'd0;
    assign perf_single_cnt = 32'd0;
    assign perf_empty_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// Directed bench for inst_fifo: hand-computed vectors checked with immediate assertions.
module tb_inst_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        write_en1, write_en2;
    logic [31:0] write_addr1, write_addr2, write_data1, write_data2;
    logic        read_en1, read_en2;
    logic [31:0] read_addr1, read_data1, read_addr2, read_data2;
    logic        fifo_empty, fifo_almost_empty, fifo_full;
    logic [31:0] perf_dual_cnt, perf_single_cnt, perf_empty_cnt;

    int vec  = 0;
    int errs = 0;

`ifdef INST_FIFO_PERF_EN
    localparam logic [31:0] EXP_DUAL = 32'd3, EXP_SINGLE = 32'd2, EXP_EMPTY = 32'd4;
`else
    localparam logic [31:0] EXP_DUAL = 32'd0, EXP_SINGLE = 32'd0, EXP_EMPTY = 32'd0;
`endif

    inst_fifo #(.DEPTH(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .write_en1         (write_en1),
        .write_en2         (write_en2),
        .write_addr1       (write_addr1),
        .write_addr2       (write_addr2),
        .write_data1       (write_data1),
        .write_data2       (write_data2),
        .read_en1          (read_en1),
        .read_en2          (read_en2),
        .read_addr1        (read_addr1),
        .read_data1        (read_data1),
        .read_addr2        (read_addr2),
        .read_data2        (read_data2),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_full         (fifo_full),
        .perf_dual_cnt     (perf_dual_cnt),
        .perf_single_cnt   (perf_single_cnt),
        .perf_empty_cnt    (perf_empty_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we1, input logic we2,
                         input logic [31:0] a1, input logic [31:0] d1,
                         input logic [31:0] a2, input logic [31:0] d2,
                         input logic re1, input logic re2, input logic fl);
        write_en1 = we1; write_en2 = we2;
        write_addr1 = a1; write_data1 = d1;
        write_addr2 = a2; write_data2 = d2;
        read_en1 = re1; read_en2 = re2;
        flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [63:0] q[$];
    int unsigned n;

    initial begin
        rst = 1'b1;
        idle();
        tick(); tick();
        chk("rst_empty",  32'(fifo_empty), 32'd1);
        chk("rst_aempty", 32'(fifo_almost_empty), 32'd0);
        chk("rst_full",   32'(fifo_full), 32'd0);
        chk("rst_pdual",  perf_dual_cnt, 32'd0);
        chk("rst_psingle", perf_single_cnt, 32'd0);
        chk("rst_pempty", perf_empty_cnt, 32'd0);
        rst = 1'b0;

        // Dual push, visible next cycle on both ports
        drive(1'b1, 1'b1, 32'h100, 32'hAAAA0001, 32'h104, 32'hAAAA0002, 1'b0, 1'b0, 1'b0);
        tick(); idle();
        chk("push2_a1", read_addr1, 32'h100);
        chk("push2_d1", read_data1, 32'hAAAA0001);
        chk("push2_a2", read_addr2, 32'h104);
        chk("push2_d2", read_data2, 32'hAAAA0002);
        chk("push2_empty", 32'(fifo_empty), 32'd0);
        chk("push2_aempty", 32'(fifo_almost_empty), 32'd0);

        drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        tick(); idle();
        chk("pop1_aempty", 32'(fifo_almost_empty), 32'd1);
        chk("pop1_a1", read_addr1, 32'h104);
        chk("pop1_d1", read_data1, 32'hAAAA0002);

        // Dual pop with one entry pops exactly one
        drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        tick(); idle();
        chk("underpop_empty", 32'(fifo_empty), 32'd1);
        chk("underpop_aempty", 32'(fifo_almost_empty), 32'd0);
        drive(1'b1, 1'b0, 32'h200, 32'h22220000, '0, '0, 1'b0, 1'b0, 1'b0);
        tick(); idle();
        chk("ptr_align_a1", read_addr1, 32'h200);
        chk("ptr_align_aempty", 32'(fifo_almost_empty), 32'd1);
        drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        tick(); idle();
        chk("ptr_align_empty", 32'(fifo_empty), 32'd1);

        // Fill to DEPTH-1, then a dual push must be dropped whole
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 32'h1000 + 32'(8*i), 32'hB0000000 + 32'(2*i),
                  32'h1004 + 32'(8*i), 32'hB0000001 + 32'(2*i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        chk("fill14_full", 32'(fifo_full), 32'd0);
        drive(1'b1, 1'b0, 32'h1038, 32'hB000000E, '0, '0, 1'b0, 1'b0, 1'b0);
        tick(); idle();
        chk("fill15_full", 32'(fifo_full), 32'd1);
        drive(1'b1, 1'b1, 32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0004, 32'hDEAD0005, 1'b0, 1'b0, 1'b0);
        tick(); idle();
        chk("drop_full", 32'(fifo_full), 32'd1);
        for (int i = 0; i < 15; i++) begin
            chk("drain_a1", read_addr1, 32'h1000 + 32'(4*i));
            chk("drain_d1", read_data1, 32'hB0000000 + 32'(i));
            if (i < 14) chk("drain_a2", read_addr2, 32'h1004 + 32'(4*i));
            drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        idle();
        chk("drain_empty", 32'(fifo_empty), 32'd1);

        // Alternating dual push / dual pop across the wrap point
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if ((c % 2) == 0) begin
                drive(1'b1, 1'b1, 32'h4000 + 4*n, 32'hC0000000 + n,
                      32'h4004 + 4*n, 32'hC0000001 + n, 1'b0, 1'b0, 1'b0);
                q.push_back({32'h4000 + 4*n, 32'hC0000000 + n});
                q.push_back({32'h4004 + 4*n, 32'hC0000001 + n});
                n += 2;
                tick();
            end else begin
                chk("wrap_a1", read_addr1, q[0][63:32]);
                chk("wrap_d1", read_data1, q[0][31:0]);
                chk("wrap_a2", read_addr2, q[1][63:32]);
                chk("wrap_d2", read_data2, q[1][31:0]);
                drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
                tick();
                void'(q.pop_front());
                void'(q.pop_front());
            end
        end
        idle();
        chk("wrap_empty", 32'(fifo_empty), 32'd1);

        // Flush beats same-cycle push and pop
        drive(1'b1, 1'b1, 32'h500, 32'h55550000, 32'h504, 32'h55550001, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h508, 32'h55550002, 32'h50C, 32'h55550003, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h510, 32'h55550004, '0, '0, 1'b0, 1'b0, 1'b0);
        tick(); idle();
        chk("pre_flush_a1", read_addr1, 32'h500);
        drive(1'b1, 1'b1, 32'hF00, 32'hFFFF0000, 32'hF04, 32'hFFFF0001, 1'b1, 1'b0, 1'b1);
        tick(); idle();
        chk("flush_empty", 32'(fifo_empty), 32'd1);
        chk("flush_aempty", 32'(fifo_almost_empty), 32'd0);
        chk("flush_full", 32'(fifo_full), 32'd0);
        drive(1'b1, 1'b0, 32'h300, 32'h33330000, '0, '0, 1'b0, 1'b0, 1'b0);
        tick(); idle();
        chk("post_flush_a1", read_addr1, 32'h300);
        chk("post_flush_aempty", 32'(fifo_almost_empty), 32'd1);

        // Asynchronous reset takes effect between edges
        drive(1'b1, 1'b1, 32'h600, 32'h66660000, 32'h604, 32'h66660001, 1'b0, 1'b0, 1'b0);
        tick(); idle();
        chk("pre_arst_empty", 32'(fifo_empty), 32'd0);
        rst = 1'b1;
        #2;
        chk("arst_empty", 32'(fifo_empty), 32'd1);
        chk("arst_aempty", 32'(fifo_almost_empty), 32'd0);
        tick();
        rst = 1'b0;

        // Perf scenario: 4 pushing edges (first sees empty), 3 dual pops, 2 single pops, 3 idle empty edges
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h700 + 32'(8*i), 32'h7000 + 32'(2*i),
                  32'h704 + 32'(8*i), 32'h7001 + 32'(2*i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        chk("perf_a1_after_dual", read_addr1, 32'h718);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        idle();
        chk("perf_q_empty", 32'(fifo_empty), 32'd1);
        tick(); tick(); tick();
        chk("perf_dual",   perf_dual_cnt,   EXP_DUAL);
        chk("perf_single", perf_single_cnt, EXP_SINGLE);
        chk("perf_emptyc", perf_empty_cnt,  EXP_EMPTY);
        rst = 1'b1;
        #2;
        chk("perf_arst_dual",   perf_dual_cnt,   32'd0);
        chk("perf_arst_single", perf_single_cnt, 32'd0);
        chk("perf_arst_empty",  perf_empty_cnt,  32'd0);
        tick();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/inst_fifo.md
# inst_fifo

Dual-write, dual-read instruction queue between the fetch stage and the dual-issue decode stage. Fetch pushes up to two (PC, instruction) pairs per cycle. Decode pops one entry when only the master pipe issues, or two when the slave pipe also issues. The block produces the `fifo_empty` / `fifo_almost_empty` status consumed by the dual-issue detect logic, and supports a one-cycle flush on branch redirect or exception.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; must be a power of two and at least 4.
- `PTR_W`, $clog2(DEPTH): pointer width. Count width is PTR_W+1.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `flush`, input, 1: synchronous queue clear.
- `write_en1`, input, 1: push entry 1.
- `write_en2`, input, 1: push entry 2; honoured only together with `write_en1`.
- `write_addr1`, `write_addr2`, input, 32: PCs of the pushed entries.
- `write_data1`, `write_data2`, input, 32: instruction words of the pushed entries.
- `read_en1`, input, 1: pop the head entry (master issue).
- `read_en2`, input, 1: pop the second entry (slave issue); honoured only together with `read_en1`.
- `read_addr1`, `read_data1`, output, 32 each: PC and instruction of the head entry.
- `read_addr2`, `read_data2`, output, 32 each: PC and instruction of the head+1 entry.
- `fifo_empty`, output, 1: asserted when count==0.
- `fifo_almost_empty`, output, 1: asserted when count==1.
- `fifo_full`, output, 1: asserted when count>=DEPTH-1, meaning a two-entry push cannot be accepted.
- `perf_dual_cnt`, output, 32: cycles in which two entries were popped.
- `perf_single_cnt`, output, 32: cycles in which exactly one entry was popped.
- `perf_empty_cnt`, output, 32: cycles in which `fifo_empty` was high.

## Operation
- State: circular storage of DEPTH entries, read pointer `rptr`, write pointer `wptr`, and `count`. Pointers wrap modulo DEPTH.
- Read outputs are combinational from storage:
  - port 1 shows entry[rptr];
  - port 2 shows entry[rptr+1 mod DEPTH].
  - Port 1 is meaningful only when count>=1, port 2 only when count>=2; otherwise the values are don't-care.
- Requested pops: npop_req = read_en1 + (read_en1 & read_en2).
- Actual pops: npop = min(npop_req, count). Popping from an empty queue is a no-op, and a dual pop with count==1 pops one. There is no underflow.
- Requested pushes: npush_req = write_en1 + (write_en1 & write_en2).
- Push acceptance:
  - the push is accepted in full only if DEPTH - count >= npush_req, using the pre-cycle count;
  - a pop in the same cycle gives no credit toward free space;
  - otherwise the whole push is dropped; partial pushes never happen.
- Entry 1 is written at wptr and entry 2 at wptr+1.
- Update: rptr += npop, wptr += npush, count += npush - npop.
- Flush has highest priority. When `flush` is high, rptr, wptr and count go to 0, and same-cycle pushes and pops are discarded.
- Storage is not reset.

## Timing
- Reset values:
  - rptr, wptr and count are 0;
  - `fifo_empty` is 1, `fifo_almost_empty` is 0, `fifo_full` is 0;
  - all perf counters are 0;
  - data outputs are don't-care.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Push at edge N: the entry is visible on the read ports and reflected in the flags from cycle N+1. There is no write-to-read bypass.
- Pop at edge N: the next entries appear on the read ports at N+1.
- Flags are registered-equivalent, decoded from `count` only, so they carry no combinational path from the inputs.
- Flush at edge N: `fifo_empty` is 1 at N+1.

## Configuration
- Macro `INST_FIFO_PERF_EN`.
- With the macro defined, the three perf counters increment as described above, saturate at 32'hFFFF_FFFF, and are cleared only by `rst`, not by `flush`.
- Without it, the counter logic is absent and the three perf outputs are tied to 0.

## Structure
- Package `inst_fifo_pkg`:
  - typedef `fifo_entry_t`, a struct of `addr[31:0]` and `data[31:0]`;
  - constant `INST_FIFO_DEPTH_DEFAULT` = 16.
- Sub-module `inst_fifo_perf`: holds the three saturating counters and is instantiated only under `INST_FIFO_PERF_EN`.

## Test plan
- Reset, then push two entries (PC 0x100/0x104, instructions 0xAAAA0001/0xAAAA0002) in one cycle. Next cycle: read port 1 shows 0x100/0xAAAA0001, port 2 shows 0x104/0xAAAA0002, empty=0, almost_empty=0.
- With count==1, assert read_en1 and read_en2. Exactly one entry is popped; next cycle empty=1 and wptr==rptr.
- Fill to count==DEPTH-1. Check full=1. A dual push is dropped entirely; count stays at 15 and the stored contents are unchanged.
- Run 40 cycles of alternating dual pushes and dual pops across the wrap boundary. Read data matches a reference queue, in order, with no loss.
- At count==5, assert flush together with a dual push and a pop. Next cycle count==0 and empty=1; the pushed PCs are never observed on the read ports.
- With `INST_FIFO_PERF_EN` defined, run 3 dual-pop cycles, 2 single-pop cycles and 4 empty cycles. Then perf_dual_cnt=3, perf_single_cnt=2, perf_empty_cnt=4; an asynchronous rst clears all three to 0.
